dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller. It sits between the datapath's data-memory port and main memory. It consumes MemWrite, the load indication (MemtoReg), the ALU address and the store data produced under Control_Unit decode. It returns load data and a stall that freezes the PC and register writeback.

---
 rtl/dcache_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// between the datapath data-memory port and main memory (4-word lines).
module dcache_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int INDEX_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  stall,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 4;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE,
        S_WDONE
    } state_t;

    state_t r_state, w_next;

    logic [31:0]           r_data  [0:LINES*4-1];
    logic [TAG_BITS-1:0]   r_tag   [0:LINES-1];
    logic [LINES-1:0]      r_valid;
    logic [1:0]            r_cnt;
    logic                  r_just_refilled;
    logic [15:0]           r_hit_count;
    logic [15:0]           r_miss_count;

    logic [INDEX_BITS-1:0] w_index;
    logic [1:0]            w_off;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic                  w_refill_we;
    logic                  w_refill_done;
    logic                  w_write_upd;
    logic                  w_hit_inc;
    logic                  w_miss_inc;
    logic                  w_unused;

    assign w_index  = addr[INDEX_BITS+3:4];
    assign w_off    = addr[3:2];
    assign w_tag    = addr[ADDR_WIDTH-1:INDEX_BITS+4];
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_unused = &{1'b0, addr[1:0]};

    assign w_refill_done = w_refill_we && (r_cnt == 2'd3);
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;

    always_comb begin
        w_next      = r_state;
        stall       = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rdata       = '0;
        w_refill_we = 1'b0;
        w_write_upd = 1'b0;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemWrite) begin
                    stall  = 1'b1;
                    w_next = S_WRITE;
                end else if (MemRead) begin
                    if (w_hit) begin
                        rdata = r_data[{w_index, w_off}];
                        // The retried load after a refill was already counted as a miss
                        w_hit_inc = !r_just_refilled;
                    end else begin
                        stall      = 1'b1;
                        w_miss_inc = 1'b1;
                        w_next     = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                stall     = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = {addr[ADDR_WIDTH-1:4], r_cnt, 2'b00};
                if (mem_ready) begin
                    w_refill_we = 1'b1;
                    if (r_cnt == 2'd3)
                        w_next = S_IDLE;
                end
            end
            S_WRITE: begin
                stall     = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata = wdata;
                if (mem_ready) begin
                    w_write_upd = w_hit;
                    w_next      = S_WDONE;
                end
            end
            S_WDONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_refill_we)
            r_data[{w_index, r_cnt}] <= mem_rdata;
        if (w_write_upd)
            r_data[{w_index, w_off}] <= wdata;
        if (w_refill_done)
            r_tag[w_index] <= w_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_cnt           <= '0;
            r_just_refilled <= 1'b0;
            r_hit_count     <= '0;
            r_miss_count    <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss_inc)
                r_cnt <= '0;
            else if (w_refill_we)
                r_cnt <= r_cnt + 2'd1;
            if (w_refill_done) begin
                r_valid[w_index] <= 1'b1;
                r_just_refilled  <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_just_refilled <= 1'b0;
            end
            if (w_hit_inc && (r_hit_count != '1))
                r_hit_count <= r_hit_count + 16'd1;
            if (w_miss_inc && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores against a
// behavioural main memory with programmable ready delay.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall, mem_rd_en, mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_count, miss_count;

    dcache_ctrl #(.ADDR_WIDTH(10), .INDEX_BITS(5)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    localparam int K_RD = 0, K_WR = 1, K_LD = 2, K_ST = 3;
    typedef struct {
        int          kind;
        logic [9:0]  a;
        logic [31:0] d;
    } ev_t;

    ev_t         q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          delay = 1;
    logic [31:0] mem [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [9:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.d = d;
        q.push_back(e);
    endtask

    // Main memory: answers each request after `delay` wait cycles.
    initial begin
        int wcnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | (i * 4);
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (rst || !(mem_rd_en || mem_wr_en)) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end else if (wcnt >= delay) begin
                mem_ready = 1'b1;
                wcnt = 0;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_wr_en) mem[mem_addr[9:2]] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on every observable DUT event.
    initial begin
        logic        prev_req = 1'b0;
        logic [9:0]  prev_addr = '0;
        logic [31:0] prev_wd = '0;
        forever begin
            int  k;
            ev_t e;
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                continue;
            end
            if (prev_req && (mem_rd_en || mem_wr_en)) begin
                chk("req_hold_addr", {22'd0, mem_addr}, {22'd0, prev_addr});
                if (mem_wr_en) chk("req_hold_wdata", mem_wdata, prev_wd);
            end
            prev_req  = (mem_rd_en || mem_wr_en) && !mem_ready;
            prev_addr = mem_addr;
            prev_wd   = mem_wdata;
            k = -1;
            if (mem_rd_en && mem_ready)                 k = K_RD;
            else if (mem_wr_en && mem_ready)            k = K_WR;
            else if (!stall && MemRead && !MemWrite)    k = K_LD;
            else if (!stall && MemWrite)                k = K_ST;
            if (k < 0) continue;
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_event: got kind %0d expected none", k);
                continue;
            end
            e = q.pop_front();
            chk("event_kind", k, e.kind);
            case (k)
                K_RD: chk("rd_addr", {22'd0, mem_addr}, {22'd0, e.a});
                K_WR: begin
                    chk("wr_addr", {22'd0, mem_addr}, {22'd0, e.a});
                    chk("wr_data", mem_wdata, e.d);
                end
                K_LD: chk("load_data", rdata, e.d);
                default: chk("store_retire_no_wr", {31'd0, mem_wr_en}, 32'd0);
            endcase
        end
    end

    task automatic do_load(input logic [9:0] a, input logic [31:0] d, input logic miss);
        int n = 1;
        if (miss)
            for (int c = 0; c < 4; c++) begin
                logic [1:0] cc = 2'(c);
                push(K_RD, {a[9:4], cc, 2'b00}, '0);
            end
        push(K_LD, a, d);
        @(posedge clk); #1;
        MemRead = 1'b1; addr = a;
        @(negedge clk);
        chk("first_stall", {31'd0, stall}, {31'd0, miss});
        chk("idle_no_rd", {31'd0, mem_rd_en}, 32'd0);
        while (stall && n < 200) begin
            @(negedge clk); n++;
        end
        if (stall) begin
            n_cmp++; n_bad++;
            $display("FAIL load_timeout: got stall 1 expected 0");
        end
        chk("load_stall_cycles", n - 1, miss ? 4 * (delay + 1) + 1 : 0);
        @(posedge clk); #1;
        MemRead = 1'b0;
    endtask

    task automatic do_store(input logic [9:0] a, input logic [31:0] d);
        int n = 1;
        push(K_WR, {a[9:2], 2'b00}, d);
        push(K_ST, a, '0);
        @(posedge clk); #1;
        MemWrite = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        while (stall && n < 200) begin
            @(negedge clk); n++;
        end
        if (stall) begin
            n_cmp++; n_bad++;
            $display("FAIL store_timeout: got stall 1 expected 0");
        end
        chk("store_stall_cycles", n - 1, delay + 2);
        @(posedge clk); #1;
        MemWrite = 1'b0;
        @(negedge clk);
        chk("post_store_idle", {31'd0, stall}, 32'd0);
    endtask

    task automatic chk_counts(input int h, input int m);
        chk("hit_count", {16'd0, hit_count}, h);
        chk("miss_count", {16'd0, miss_count}, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, n;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk_counts(0, 0);

        do_load(10'h040, 32'hC0DE_0040, 1'b1);  chk_counts(0, 1);
        do_load(10'h048, 32'hC0DE_0048, 1'b0);  chk_counts(1, 1);
        delay = 2;
        do_store(10'h044, 32'hDEAD_BEEF);       chk_counts(1, 1);
        delay = 1;
        do_load(10'h044, 32'hDEAD_BEEF, 1'b0);  chk_counts(2, 1);
        do_store(10'h3F0, 32'h1234_5678);
        do_load(10'h3F0, 32'h1234_5678, 1'b1);  chk_counts(2, 2);
        do_load(10'h3F4, 32'hC0DE_03F4, 1'b0);  chk_counts(3, 2);
        do_load(10'h240, 32'hC0DE_0240, 1'b1);  chk_counts(3, 3);
        do_load(10'h040, 32'hC0DE_0040, 1'b1);  chk_counts(3, 4);
        do_load(10'h044, 32'hDEAD_BEEF, 1'b0);  chk_counts(4, 4);

        // Reset in the middle of a refill, after two words have arrived.
        delay = 3;
        push(K_RD, 10'h080, '0);
        push(K_RD, 10'h084, '0);
        @(posedge clk); #1;
        MemRead = 1'b1; addr = 10'h080;
        hs = 0; n = 0;
        while (hs < 2 && n < 200) begin
            @(negedge clk); n++;
            if (mem_rd_en && mem_ready) hs++;
        end
        if (hs < 2) begin
            n_cmp++; n_bad++;
            $display("FAIL refill_progress_timeout: got %0d handshakes expected 2", hs);
        end
        @(posedge clk); #1;
        rst = 1'b1; MemRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk_counts(0, 0);
        delay = 1;
        do_load(10'h080, 32'hC0DE_0080, 1'b1);  chk_counts(0, 1);
        do_load(10'h040, 32'hC0DE_0040, 1'b1);  chk_counts(0, 2);

        repeat (3) @(posedge clk);
        chk("scoreboard_leftover", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
